// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: 4-entry in-order tracker of predicted branches with
// misprediction flush/redirect and predictor training. Optional stats: BP_STATS_EN.
module branch_recovery_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_issue,
  input  logic        issue_pred,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_imm,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic        stall,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic        upd_taken,
  output logic [2:0]  outstanding,
  output logic        err_underflow
`ifdef BP_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispred
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned STA_W = 16;

  typedef enum logic [1:0] {IDLE, TRACK, RECOVER} state_e;

  typedef struct packed {
    logic            pred;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } entry_t;

  state_e             state_q, state_d;
  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               stall_q, stall_d, flush_q, flush_d;
  logic               upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    redirect_q, redirect_d;
  logic               push, pop, mispred;
  entry_t             head;
`ifdef BP_STATS_EN
  logic [STA_W-1:0]   stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
`endif

  // Next-state: resolve head, detect misprediction, accept issues.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    flush_d     = 1'b0;
    redirect_d  = redirect_q;
    upd_valid_d = 1'b0;
    upd_taken_d = 1'b0;
    err_d       = err_q;
    push        = 1'b0;
    pop         = 1'b0;
    mispred     = 1'b0;
    head        = fifo_q[rd_ptr_q];
`ifdef BP_STATS_EN
    stat_br_d   = stat_br_q;
    stat_mp_d   = stat_mp_q;
`endif
    case (state_q)
      RECOVER: state_d = IDLE;
      default: begin
        push = br_issue && !stall_q;
        if (res_valid) begin
          if (count_q == '0) begin
            err_d = 1'b1;
          end else begin
            pop         = 1'b1;
            upd_valid_d = 1'b1;
            upd_taken_d = res_taken;
            if (res_taken != head.pred) begin
              mispred    = 1'b1;
              push       = 1'b0;
              flush_d    = 1'b1;
              redirect_d = res_taken ? head.pc + head.imm : head.pc + XLEN'(4);
            end
          end
        end
        if (mispred) begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = RECOVER;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(pop);
          wr_ptr_d = wr_ptr_q + PTR_W'(push);
          count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
          state_d  = (count_d == '0) ? IDLE : TRACK;
        end
      end
    endcase
    stall_d = (count_d == CNT_W'(DEPTH)) || (state_d == RECOVER);
`ifdef BP_STATS_EN
    if (pop && stat_br_q != {STA_W{1'b1}}) stat_br_d = stat_br_q + STA_W'(1);
    if (mispred && stat_mp_q != {STA_W{1'b1}}) stat_mp_d = stat_mp_q + STA_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
`ifdef BP_STATS_EN
      stat_br_q   <= '0;
      stat_mp_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      upd_valid_q <= upd_valid_d;
      upd_taken_q <= upd_taken_d;
      err_q       <= err_d;
      if (push) fifo_q[wr_ptr_q] <= '{pred: issue_pred, pc: issue_pc, imm: issue_imm};
`ifdef BP_STATS_EN
      stat_br_q   <= stat_br_d;
      stat_mp_q   <= stat_mp_d;
`endif
    end
  end

  assign stall         = stall_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign upd_valid     = upd_valid_q;
  assign upd_taken     = upd_taken_q;
  assign outstanding   = count_q;
  assign err_underflow = err_q;
`ifdef BP_STATS_EN
  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed plus random bench for branch_recovery_ctrl against a queue-based model.
module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_issue = 1'b0, issue_pred = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] issue_pc = '0, issue_imm = '0;
  logic        stall, flush, upd_valid, upd_taken, err_underflow;
  logic [31:0] redirect_pc;
  logic [2:0]  outstanding;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches, stat_mispred;
`endif

  branch_recovery_ctrl dut (
    .clk(clk), .reset(reset), .br_issue(br_issue), .issue_pred(issue_pred),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .res_valid(res_valid),
    .res_taken(res_taken), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .outstanding(outstanding),
    .err_underflow(err_underflow)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    logic [31:0] pc;
    logic [31:0] imm;
  } ent_t;

  ent_t        mq[$];
  bit          m_recover, m_flush, m_upd_valid, m_upd_taken, m_err;
  logic [31:0] m_redirect;
  int unsigned m_br, m_mp;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".outstanding"}, 32'(outstanding), 32'(mq.size()));
    check({tag, ".stall"}, 32'(stall), 32'((mq.size() == 4) || m_recover));
    check({tag, ".flush"}, 32'(flush), 32'(m_flush));
    check({tag, ".redirect"}, redirect_pc, m_redirect);
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'(m_upd_valid));
    if (m_upd_valid) check({tag, ".upd_taken"}, 32'(upd_taken), 32'(m_upd_taken));
    check({tag, ".err"}, 32'(err_underflow), 32'(m_err));
`ifdef BP_STATS_EN
    check({tag, ".stat_br"}, 32'(stat_branches), m_br);
    check({tag, ".stat_mp"}, 32'(stat_mispred), m_mp);
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    m_recover = 0; m_flush = 0; m_upd_valid = 0; m_upd_taken = 0; m_err = 0;
    m_redirect = '0; m_br = 0; m_mp = 0;
  endtask

  // Reset is checked asynchronously (between edges) and again after a held edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    br_issue = 0; res_valid = 0;
    #2;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk); #1;
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  task automatic step(input bit br, input bit pr, input logic [31:0] pc, input logic [31:0] imm,
                      input bit rv, input bit rt, input string tag);
    bit   accept;
    ent_t h;
    br_issue = br; issue_pred = pr; issue_pc = pc; issue_imm = imm;
    res_valid = rv; res_taken = rt;
    accept = br && !((mq.size() == 4) || m_recover);
    m_flush = 0; m_upd_valid = 0; m_upd_taken = 0;
    if (m_recover) begin
      m_recover = 0;
    end else begin
      if (rv) begin
        if (mq.size() == 0) begin
          m_err = 1;
        end else begin
          h = mq.pop_front();
          m_upd_valid = 1; m_upd_taken = rt;
          if (m_br != 16'hFFFF) m_br++;
          if (rt != h.pred) begin
            m_flush = 1;
            m_redirect = rt ? h.pc + h.imm : h.pc + 32'd4;
            mq.delete();
            m_recover = 1;
            accept = 0;
            if (m_mp != 16'hFFFF) m_mp++;
          end
        end
      end
      if (accept) mq.push_back('{pred: pr, pc: pc, imm: imm});
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    bit rt;
    #1;
    do_reset("reset0");

    // Correct taken prediction trains without flush.
    step(1, 1, 32'h100, 32'h20, 0, 0, "c1.issue");
    step(0, 0, 0, 0, 1, 1, "c1.res");
    check("c1.upd_valid", 32'(upd_valid), 32'd1);
    check("c1.upd_taken", 32'(upd_taken), 32'd1);
    check("c1.flush", 32'(flush), 32'd0);

    // Mispredicted not-taken: redirect to target, one-cycle recover stall.
    step(1, 0, 32'h100, 32'h20, 0, 0, "c2.issue");
    step(1, 1, 32'h300, 32'h8, 1, 1, "c2.res");
    check("c2.flush", 32'(flush), 32'd1);
    check("c2.redirect", redirect_pc, 32'h120);
    check("c2.outstanding", 32'(outstanding), 32'd0);
    check("c2.stall", 32'(stall), 32'd1);
    step(1, 1, 32'h400, 32'h8, 1, 0, "c2.recover");
    check("c2.stall_after", 32'(stall), 32'd0);
    check("c2.flush_after", 32'(flush), 32'd0);
    check("c2.redirect_hold", redirect_pc, 32'h120);

    // Not-taken fall-through wraps to zero.
    step(1, 1, 32'hFFFF_FFFC, 32'h40, 0, 0, "c3.issue");
    step(0, 0, 0, 0, 1, 0, "c3.res");
    check("c3.redirect", redirect_pc, 32'h0);
    check("c3.flush", 32'(flush), 32'd1);
    step(0, 0, 0, 0, 0, 0, "c3.recover");

    // Fill to four, fifth issue dropped, one resolve frees a slot.
    for (int i = 0; i < 4; i++) step(1, 1, 32'h200 + 32'(4 * i), 32'h10, 0, 0, "c4.fill");
    check("c4.full_cnt", 32'(outstanding), 32'd4);
    check("c4.full_stall", 32'(stall), 32'd1);
    step(1, 1, 32'h500, 32'h10, 0, 0, "c4.drop");
    check("c4.drop_cnt", 32'(outstanding), 32'd4);
    step(0, 0, 0, 0, 1, 1, "c4.res");
    check("c4.res_cnt", 32'(outstanding), 32'd3);
    check("c4.res_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, "c4.drain");

    // Underflow is sticky and only reset clears it.
    step(0, 0, 0, 0, 1, 1, "c5.under");
    check("c5.err", 32'(err_underflow), 32'd1);
    check("c5.upd_valid", 32'(upd_valid), 32'd0);
    step(0, 0, 0, 0, 0, 0, "c5.sticky");
    check("c5.err_sticky", 32'(err_underflow), 32'd1);
    do_reset("c5.reset");
    check("c5.err_clr", 32'(err_underflow), 32'd0);

    // Reset while in recover aborts the flush pulse.
    step(1, 0, 32'h700, 32'h100, 0, 0, "c6.issue");
    step(0, 0, 0, 0, 1, 1, "c6.res");
    do_reset("c6.reset");

`ifdef BP_STATS_EN
    step(1, 1, 32'h10, 32'h4, 0, 0, "c7.i0");
    step(1, 1, 32'h20, 32'h4, 1, 1, "c7.r0");
    step(1, 0, 32'h30, 32'h4, 1, 1, "c7.r1");
    step(0, 0, 0, 0, 1, 1, "c7.r2");
    check("c7.stat_br", 32'(stat_branches), 32'd3);
    check("c7.stat_mp", 32'(stat_mispred), 32'd1);
    step(0, 0, 0, 0, 0, 0, "c7.recover");
`endif

    // Random traffic, mostly-correct predictions so the tracker fills up.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rnd.reset");
      rt = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].pred : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           ($urandom_range(0, 9) < 3), rt, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 The block SHALL provide port: reset  input  1  asynchronous reset, active when 0.
REQ-004 The block SHALL provide port: br_issue  input  1  conditional branch (IR[6:2]==5'b11000) fetched this cycle.
REQ-005 The block SHALL provide port: issue_pred  input  1  predictor direction for the issued branch (1 = taken).
REQ-006 The block SHALL provide port: issue_pc  input  32  PC of the issued branch.
REQ-007 The block SHALL provide port: issue_imm  input  32  sign-extended B-type offset of the issued branch.
REQ-008 The block SHALL provide port: res_valid  input  1  oldest outstanding branch resolved in EX this cycle.
REQ-009 The block SHALL provide port: res_taken  input  1  actual direction of the resolving branch.
REQ-010 The block SHALL provide port: stall  output  1  fetch must hold; br_issue is not accepted.
REQ-011 The block SHALL provide port: flush  output  1  one-cycle pulse that squashes younger instructions.
REQ-012 The block SHALL provide port: redirect_pc  output  32  corrected fetch PC, valid while flush=1.
REQ-013 The block SHALL provide port: upd_valid  output  1  one-cycle predictor-training pulse.
REQ-014 The block SHALL provide port: upd_taken  output  1  training direction, valid while upd_valid=1.
REQ-015 The block SHALL provide port: outstanding  output  3  number of tracked branches, 0..4.
REQ-016 The block SHALL provide port: err_underflow  output  1  sticky flag set by res_valid while empty.

Function
REQ-017 The block SHALL track outstanding branches in a 4-entry in-order FIFO of {pred, pc, imm}.
REQ-018 FSM states SHALL be IDLE (empty), TRACK (1..4 entries) and RECOVER (one-cycle flush).
REQ-019 The block SHALL push an entry when br_issue=1 and stall=0.
REQ-020 stall SHALL be 1 when outstanding==4 or the state is RECOVER, and 0 otherwise, including a full cycle with res_valid=1.
REQ-021 The block SHALL pop the head entry when res_valid=1 in IDLE/TRACK; a push and pop in the same cycle SHALL leave the count unchanged.
REQ-022 A resolution in cycle N SHALL produce registered outputs in cycle N+1: upd_valid=1 and upd_taken=res_taken.
REQ-023 A misprediction SHALL be res_taken != head.pred.
REQ-024 On a misprediction in cycle N, the block SHALL, in cycle N+1, assert flush=1 and drive redirect_pc = res_taken ? pc+imm : pc+4, using 32-bit wrap-around arithmetic.
REQ-025 On a misprediction, the block SHALL discard all entries, ignore any same-cycle push, set outstanding to 0 and enter RECOVER.
REQ-026 RECOVER SHALL last exactly one cycle, then go to IDLE; res_valid and br_issue SHALL be ignored in RECOVER.
REQ-027 A correct prediction SHALL leave flush=0 and redirect_pc unchanged.
REQ-028 res_valid with an empty FIFO SHALL set err_underflow, with no pop, no upd_valid and no flush.
REQ-029 TRACK SHALL go to IDLE when the last entry pops without a push.

Reset
REQ-030 While reset=0, the block SHALL be in IDLE with the FIFO empty and pointers at 0.
REQ-031 While reset=0, stall, flush, upd_valid, upd_taken, err_underflow SHALL be 0, redirect_pc SHALL be 32'h0 and outstanding SHALL be 0.
REQ-032 Reset asserted mid-operation, including in RECOVER, SHALL discard all entries and abort any pending pulse immediately.

Configuration
REQ-033 With macro BP_STATS_EN defined, the block SHALL add outputs stat_branches[15:0] (resolutions) and stat_mispred[15:0] (mispredictions), both saturating at 16'hFFFF and reset to 0.
REQ-034 Without BP_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL cover: issue pc=0x100, imm=0x20, pred=1; resolve taken -> upd_valid=1, upd_taken=1, flush=0.
REQ-036 Bench SHALL cover: issue pc=0x100, imm=0x20, pred=0; resolve taken -> next cycle flush=1, redirect_pc=0x120, outstanding=0, stall=1 for one cycle.
REQ-037 Bench SHALL cover: issue pc=0xFFFFFFFC, pred=1; resolve not-taken -> redirect_pc=0x00000000.
REQ-038 Bench SHALL cover: 4 issues without resolution -> outstanding=4, stall=1, a 5th br_issue is dropped; one resolve -> outstanding=3, stall=0.
REQ-039 Bench SHALL cover: res_valid with an empty FIFO -> err_underflow=1 (sticky), upd_valid=0; reset=0 -> err_underflow=0.
REQ-040 Bench SHALL cover, with BP_STATS_EN: 3 resolutions with 1 misprediction -> stat_branches=3, stat_mispred=1.
